// File: rtl/bht_ctrl.sv
// Branch history table controller: owns the table write port, walks the table
// clear after reset/flush, serialises EX updates and keeps prediction statistics.
module bht_ctrl #(
    parameter int IDX_W = 7,
    parameter int DEPTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_req,
    input  logic             stat_clr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic             upd_pred,
    output logic [IDX_W-1:0] tbl_raddr,
    input  logic [1:0]       tbl_rdata,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_waddr,
    output logic [1:0]       tbl_wdata,
    output logic             ready,
    output logic [CNT_W-1:0] correct_count,
    output logic [CNT_W-1:0] wrong_count
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic             we_nxt;
    logic [IDX_W-1:0] waddr_nxt;
    logic [1:0]       wdata_nxt;
    logic             ready_nxt;
    logic [CNT_W-1:0] correct_nxt, wrong_nxt;
    logic [1:0]       cur;
    logic             accept;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        case (c)
            2'b00:        n = taken ? 2'b01 : 2'b00;
            2'b01, 2'b10: n = taken ? 2'b11 : 2'b00;
            default:      n = taken ? 2'b11 : 2'b10;
        endcase
        return n;
    endfunction

    assign tbl_raddr = upd_pc;

    // The registered write has not reached the array yet, so it shadows the read.
    assign cur    = (tbl_we && (tbl_waddr == upd_pc)) ? tbl_wdata : tbl_rdata;
    assign accept = (state == RUN) && upd_valid && !flush_req;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        we_nxt    = 1'b0;
        waddr_nxt = tbl_waddr;
        wdata_nxt = tbl_wdata;
        ready_nxt = ready;
        case (state)
            CLEAR, FLUSH: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                    ptr_nxt   = '0;
                    ready_nxt = 1'b0;
                end else begin
                    we_nxt    = 1'b1;
                    waddr_nxt = ptr;
                    wdata_nxt = 2'b00;
                    ptr_nxt   = ptr + 1'b1;
                    if (ptr == IDX_W'(DEPTH - 1)) begin
                        state_nxt = RUN;
                        ready_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                    ptr_nxt   = '0;
                    ready_nxt = 1'b0;
                end else if (upd_valid) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = upd_pc;
                    wdata_nxt = ctr_next(cur, upd_taken);
                end
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = '0;
                ready_nxt = 1'b0;
            end
        endcase
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_comb begin
        correct_nxt = correct_count;
        wrong_nxt   = wrong_count;
        if (stat_clr) begin
            correct_nxt = '0;
            wrong_nxt   = '0;
        end else if (accept) begin
            if (upd_taken == upd_pred) begin
                if (correct_count != {CNT_W{1'b1}})
                    correct_nxt = correct_count + CNT_W'(1);
            end else begin
                if (wrong_count != {CNT_W{1'b1}})
                    wrong_nxt = wrong_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= CLEAR;
            ptr           <= '0;
            tbl_we        <= 1'b0;
            tbl_waddr     <= '0;
            tbl_wdata     <= 2'b00;
            ready         <= 1'b0;
            correct_count <= '0;
            wrong_count   <= '0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            tbl_we        <= we_nxt;
            tbl_waddr     <= waddr_nxt;
            tbl_wdata     <= wdata_nxt;
            ready         <= ready_nxt;
            correct_count <= correct_nxt;
            wrong_count   <= wrong_nxt;
        end
    end

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a logical table model.
module tb_bht_ctrl;

    localparam int IDX_W = 7;
    localparam int DEPTH = 128;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush_req = 1'b0;
    logic             stat_clr = 1'b0;
    logic             upd_valid = 1'b0;
    logic [IDX_W-1:0] upd_pc = '0;
    logic             upd_taken = 1'b0;
    logic             upd_pred = 1'b0;
    logic [IDX_W-1:0] tbl_raddr;
    logic [1:0]       tbl_rdata;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_waddr;
    logic [1:0]       tbl_wdata;
    logic             ready;
    logic [CNT_W-1:0] correct_count;
    logic [CNT_W-1:0] wrong_count;

    logic [1:0] mem [DEPTH];
    logic       holdStale = 1'b0;

    int assertCount = 0;
    int failCount   = 0;

    // Behavioural model state: logical table contents and walk progress
    logic [1:0] modelTbl [DEPTH];
    bit  running;
    int  walkIdx;
    bit  expWe, expReady;
    int  expWaddr, expWdata, expCorrect, expWrong;

    bht_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .stat_clr(stat_clr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata), .tbl_we(tbl_we),
        .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata), .ready(ready),
        .correct_count(correct_count), .wrong_count(wrong_count)
    );

    always #5 clk = ~clk;

    // Table storage: asynchronous read, synchronous write; holdStale pins reads at 00.
    assign tbl_rdata = holdStale ? 2'b00 : mem[tbl_raddr];
    always @(posedge clk) begin
        if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
    end

    function automatic logic [1:0] bhtNext(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd0) ? 2'd1 : 2'd3;
        return (c == 2'd3) ? 2'd2 : 2'd0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic c, input logic v,
                                 input logic [IDX_W-1:0] pc, input logic t, input logic p);
        @(negedge clk);
        #1;
        flush_req = f;
        stat_clr  = c;
        upd_valid = v;
        upd_pc    = pc;
        upd_taken = t;
        upd_pred  = p;
    endtask

    task automatic afterEdge;
        @(posedge clk);
        #1;
    endtask

    // Expects the inputs for walk edge 0 to be driven already.
    task automatic checkWalk(input string tag, input bit withUpdates);
        for (int i = 0; i < DEPTH; i++) begin
            afterEdge();
            checkOutput({tag, "_we"}, tbl_we, 1);
            checkOutput({tag, "_waddr"}, tbl_waddr, i);
            checkOutput({tag, "_wdata"}, tbl_wdata, 0);
            checkOutput({tag, "_ready"}, ready, (i == DEPTH - 1) ? 1 : 0);
            if (withUpdates && i < DEPTH - 1)
                applyStimulus(1'b0, 1'b0, 1'b1, IDX_W'($urandom_range(0, DEPTH - 1)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    // Model steps once per cycle for the edge just passed, then compares.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                running = 0; walkIdx = 0; expWe = 0; expReady = 0;
                expWaddr = 0; expWdata = 0; expCorrect = 0; expWrong = 0;
            end else begin
                bit accept;
                accept = running && upd_valid && !flush_req;
                if (!running) begin
                    if (flush_req) begin
                        walkIdx = 0;
                        expWe   = 0;
                    end else begin
                        expWe = 1; expWaddr = walkIdx; expWdata = 0;
                        modelTbl[walkIdx] = 2'd0;
                        if (walkIdx == DEPTH - 1) begin
                            running  = 1;
                            expReady = 1;
                        end
                        walkIdx = (walkIdx + 1) % DEPTH;
                    end
                end else if (flush_req) begin
                    running = 0; expReady = 0; walkIdx = 0; expWe = 0;
                end else if (upd_valid) begin
                    modelTbl[upd_pc] = bhtNext(modelTbl[upd_pc], upd_taken);
                    expWe = 1; expWaddr = upd_pc; expWdata = modelTbl[upd_pc];
                end else begin
                    expWe = 0;
                end
                if (stat_clr) begin
                    expCorrect = 0;
                    expWrong   = 0;
                end else if (accept) begin
                    if (upd_taken == upd_pred) expCorrect = (expCorrect == 65535) ? 65535 : expCorrect + 1;
                    else                       expWrong   = (expWrong == 65535) ? 65535 : expWrong + 1;
                end
            end
            checkOutput("m_ready", ready, expReady);
            checkOutput("m_we", tbl_we, expWe);
            if (expWe) begin
                checkOutput("m_waddr", tbl_waddr, expWaddr);
                checkOutput("m_wdata", tbl_wdata, expWdata);
            end
            checkOutput("m_correct", correct_count, expCorrect);
            checkOutput("m_wrong", wrong_count, expWrong);
            checkOutput("m_raddr", tbl_raddr, upd_pc);
        end
    end

    initial begin
        int bad;
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(1, 3));

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_we", tbl_we, 0);
        checkOutput("rst_waddr", tbl_waddr, 0);
        checkOutput("rst_correct", correct_count, 0);
        checkOutput("rst_wrong", wrong_count, 0);

        // Initial clear walk
        rst = 1'b0;
        checkWalk("init", 1'b0);
        afterEdge();
        checkOutput("run_idle_we", tbl_we, 0);
        checkOutput("run_ready", ready, 1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 2'b00) bad++;
        checkOutput("mem_cleared", bad, 0);

        // Forwarding chain on pc 5 with stale read data
        holdStale = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, 1'b1, 1'b1); afterEdge();
        checkOutput("pc5_a_waddr", tbl_waddr, 5);
        checkOutput("pc5_a_wdata", tbl_wdata, 1);
        checkOutput("pc5_a_correct", correct_count, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, 1'b1, 1'b0); afterEdge();
        checkOutput("pc5_b_wdata", tbl_wdata, 3);
        checkOutput("pc5_b_wrong", wrong_count, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, 1'b1, 1'b1); afterEdge();
        checkOutput("pc5_c_wdata", tbl_wdata, 3);
        checkOutput("pc5_c_correct", correct_count, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        holdStale = 1'b0;

        // pc 9: build to 11, then not-taken and taken
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd9, 1'b1, 1'b1); afterEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd9, 1'b1, 1'b1); afterEdge();
        checkOutput("pc9_sat_wdata", tbl_wdata, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd9, 1'b0, 1'b1); afterEdge();
        checkOutput("pc9_nt_wdata", tbl_wdata, 2);
        checkOutput("pc9_nt_wrong", wrong_count, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd9, 1'b1, 1'b1); afterEdge();
        checkOutput("pc9_t_wdata", tbl_wdata, 3);
        checkOutput("pc9_t_correct", correct_count, 5);

        // Flush with a simultaneous update
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd3, 1'b1, 1'b1); afterEdge();
        checkOutput("flush_we", tbl_we, 0);
        checkOutput("flush_ready", ready, 0);
        checkOutput("flush_correct", correct_count, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        checkWalk("flush", 1'b0);
        checkOutput("flush_post_correct", correct_count, 5);
        checkOutput("flush_post_wrong", wrong_count, 2);

        // Flush again at walk cycle 60, updates ignored throughout
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0); afterEdge();
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, IDX_W'($urandom_range(0, DEPTH - 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            afterEdge();
            checkOutput("w60_waddr", tbl_waddr, i);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 7'd7, 1'b1, 1'b0); afterEdge();
        checkOutput("w60_ready", ready, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd7, 1'b0, 1'b0);
        checkWalk("reflush", 1'b1);
        checkOutput("reflush_correct", correct_count, 5);
        checkOutput("reflush_wrong", wrong_count, 2);

        // stat_clr with a correct update, then saturate wrong_count
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd1, 1'b1, 1'b1); afterEdge();
        checkOutput("clr_correct", correct_count, 0);
        checkOutput("clr_wrong", wrong_count, 0);
        checkOutput("clr_we", tbl_we, 1);
        for (int n = 0; n < 65535; n++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, 1'b0, 1'b1, IDX_W'($urandom_range(0, DEPTH - 1)), t, ~t);
        end
        afterEdge();
        checkOutput("sat_full", wrong_count, 16'hFFFF);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd2, 1'b0, 1'b1); afterEdge();
        checkOutput("sat_hold", wrong_count, 16'hFFFF);
        checkOutput("sat_correct", correct_count, 0);

        // Randomized traffic, biased to a few indices to exercise forwarding
        for (int n = 0; n < 3000; n++) begin
            logic [IDX_W-1:0] pc;
            pc = ($urandom_range(0, 1) == 1) ? IDX_W'($urandom_range(0, 3))
                                             : IDX_W'($urandom_range(0, DEPTH - 1));
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 79) == 0,
                          $urandom_range(0, 9) < 7, pc,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a flush walk
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_we", tbl_we, 0);
        checkOutput("midrst_ready", ready, 0);
        checkOutput("midrst_correct", correct_count, 0);
        checkOutput("midrst_wrong", wrong_count, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        checkWalk("postrst", 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bht_ctrl.md
Name: bht_ctrl

Overview:
- Sequencer and write-port owner for the 128-entry 2-bit branch history table (BHT).
- Replaces the table's reset-time bulk clear with a one-entry-per-cycle walk. Supports a runtime flush.
- Serialises EX-stage counter updates through a single registered write port, with same-address forwarding.
- Keeps the prediction correct/wrong statistics. Sits between the EX stage and the BHT storage array, which has an asynchronous read and a synchronous write.

Parameters:
- IDX_W, 7, table index width.
- DEPTH, 128, number of table entries; equals 2**IDX_W.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_req  in  1  one-cycle request to clear the whole table.
- stat_clr  in  1  zero both statistics counters.
- upd_valid  in  1  EX stage resolved a branch this cycle (branch type is not NOBRANCH).
- upd_pc  in  IDX_W  table index of the resolved branch.
- upd_taken  in  1  actual branch outcome.
- upd_pred  in  1  prediction that was made for this branch.
- tbl_raddr  out  IDX_W  table read index; combinational, equal to upd_pc.
- tbl_rdata  in  2  table read data, asynchronous.
- tbl_we  out  1  table write enable (registered).
- tbl_waddr  out  IDX_W  table write index (registered).
- tbl_wdata  out  2  table write data (registered).
- ready  out  1  table valid; fetch must predict not-taken while low (registered).
- correct_count  out  CNT_W  count of correct predictions.
- wrong_count  out  CNT_W  count of wrong predictions.

Behaviour:
- Reset values: state CLEAR, ptr = 0, tbl_we = 0, tbl_waddr = 0, tbl_wdata = 00, ready = 0, both counters = 0.
- State CLEAR:
  - Each edge registers tbl_we = 1, tbl_waddr = ptr, tbl_wdata = 00, then ptr increments.
  - At the edge that registers ptr = DEPTH-1, state goes to RUN and ready goes to 1.
  - Edges 0..127 after reset release register writes to addresses 0..127. ready = 1 after edge 127. The final write commits at edge 128.
- State RUN, upd_valid = 1 and no flush_req:
  - Take cur = tbl_rdata. If tbl_we = 1 and tbl_waddr == upd_pc, take cur = tbl_wdata instead (forwarding).
  - Register tbl_we = 1, tbl_waddr = upd_pc, tbl_wdata = next(cur, upd_taken).
  - next() for taken / not-taken: 00 → 01 / 00; 01 → 11 / 00; 10 → 11 / 00; 11 → 11 / 10.
  - Latency: the write is presented one cycle after the update is sampled and commits at the following edge.
  - Back-to-back updates to the same index must chain correctly through forwarding.
- State RUN, upd_valid = 0: register tbl_we = 0.
- flush_req while in RUN:
  - State goes to FLUSH, ptr = 0, ready = 0 at the same edge.
  - A simultaneous update is dropped: no write and no statistics change.
  - FLUSH behaves exactly like CLEAR.
- flush_req while in CLEAR or FLUSH: ptr restarts at 0 and the walk begins again.
- Updates outside RUN are ignored: no table write, no statistics change.
- Statistics:
  - Counting happens only in RUN, with upd_valid = 1 and flush_req = 0.
  - If upd_taken == upd_pred, correct_count increments; otherwise wrong_count increments.
  - Both counters saturate at all-ones.
  - stat_clr zeros both counters and overrides an increment on the same edge.
  - flush does not clear the counters; rst does.
- rst mid-operation: asynchronous return to the reset values; any pending registered write is discarded (tbl_we = 0) and the clear walk restarts.

Test Plan:
- Release rst, idle → tbl_we = 1 for exactly 128 cycles with tbl_waddr 0..127 and tbl_wdata = 00; ready rises after edge 127; every table entry reads 00.
- RUN, three taken updates to pc 5 on consecutive cycles with tbl_rdata held at the stale 00 → tbl_wdata sequence 01, 11, 11 (forwarding); correct_count increments only where upd_pred == upd_taken.
- RUN, entry at 11, one not-taken update then one taken update to pc 9 → tbl_wdata 10 then 11; with upd_pred = 1 both times, wrong_count += 1 and correct_count += 1.
- flush_req and upd_valid on the same cycle in RUN → no update write; ready = 0 next cycle; 128-cycle clear follows; counters unchanged.
- flush_req at walk cycle 60 → tbl_waddr returns to 0; ready rises only after a further 128 writes; updates issued during the walk produce no writes.
- Preload wrong_count = 16'hFFFF and apply one mispredict → stays 16'hFFFF. stat_clr together with a correct update → both counters 0. rst asserted mid-flush → tbl_we = 0 and ready = 0 immediately.
